// File: rtl/note_playback_ctrl_if.sv
// Sample-path bundle between the playback controller, the note ROM and the codec.
// The controller side is the master: it drives the ROM address and the codec write.
interface note_playback_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              write_ready;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;

  modport master (
    output rom_addr, write, writedata_left, writedata_right,
    input  rom_q, write_ready
  );

  modport slave (
    input  rom_addr, write, writedata_left, writedata_right,
    output rom_q, write_ready
  );
endinterface

// File: rtl/note_playback_ctrl.sv
// Handshaked note playback sequencer: steps the ROM over a latched range, waits out
// the ROM read latency, attenuates each sample and hands it to the codec as an L/R pair.
module note_playback_ctrl #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [1:0]        vol,
  output logic              busy,
  output logic              done,
  note_playback_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, WRITE} state_e;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [1:0]        vol_q, vol_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic              fresh_q, fresh_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    start_d     = start_q;
    end_d       = end_q;
    vol_d       = vol_q;
    wait_cnt_d  = wait_cnt_q;
    fresh_d     = fresh_q;
    writedata_d = writedata_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (play && !stop) begin
          start_d = start_addr;
          end_d   = end_addr;
          vol_d   = vol;
          if (start_addr > end_addr) begin
            done_d = 1'b1;
          end else begin
            rom_addr_d = start_addr;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        wait_cnt_d = WAIT_INIT;
        if (RD_LAT == 1) begin
          state_d = HOLD;
          fresh_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 2'd1;
        if (wait_cnt_q == 2'd1) begin
          state_d = HOLD;
          fresh_d = 1'b1;
        end
      end
      HOLD: begin
        // rom_q is valid in the first HOLD cycle; later cycles keep the captured word.
        if (fresh_q) begin
          writedata_d = DATA_W'($signed(bus.rom_q) >>> vol_q);
          fresh_d     = 1'b0;
        end
        if (bus.write_ready) state_d = WRITE;
      end
      WRITE: begin
        if (rom_addr_q == end_q) begin
          if (loop_en) begin
            rom_addr_d = start_q;
            state_d    = FETCH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every transition above; the address and output word are left as is.
    if (stop && state_q != IDLE) begin
      state_d     = IDLE;
      done_d      = 1'b1;
      rom_addr_d  = rom_addr_q;
      writedata_d = writedata_q;
      fresh_d     = 1'b0;
    end
  end

  assign write_d = (state_d == WRITE);
  assign busy_d  = (state_d != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      start_q     <= '0;
      end_q       <= '0;
      vol_q       <= '0;
      wait_cnt_q  <= '0;
      fresh_q     <= 1'b0;
      writedata_q <= '0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      start_q     <= start_d;
      end_q       <= end_d;
      vol_q       <= vol_d;
      wait_cnt_q  <= wait_cnt_d;
      fresh_q     <= fresh_d;
      writedata_q <= writedata_d;
      write_q     <= write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rom_addr        = rom_addr_q;
  assign bus.write           = write_q;
  assign bus.writedata_left  = writedata_q;
  assign bus.writedata_right = writedata_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule
